// File: rtl/clock_counter.sv
// mm:ss timekeeping core: MCLK prescaler to a 1 s tick, four BCD digits 00:00..59:59, load on set-mode exit.
// Latency: digits, sec_tick and rollover are registered and update on the tick edge itself.
// Backpressure: none; set_en freezes time and holds the prescaler at 0.
module clock_counter #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       set_en,
    input  logic       clear,
    input  logic [3:0] set_min10,
    input  logic [3:0] set_min01,
    input  logic [3:0] set_sec10,
    input  logic [3:0] set_sec01,
    output logic [3:0] cur_min10,
    output logic [3:0] cur_min01,
    output logic [3:0] cur_sec10,
    output logic [3:0] cur_sec01,
    output logic       sec_tick,
    output logic       rollover
);

    logic [CNT_W-1:0] presc;
    logic             prev_set;
    logic             presc_end;
    logic             load_edge;
    logic [3:0]       nxt_min10, nxt_min01, nxt_sec10, nxt_sec01;
    logic             wrap_all;

    assign presc_end = (presc == CNT_W'(TICK_DIV - 1));
    assign load_edge = prev_set && !set_en;

    // Carry chain: every digit that wraps hands its carry to the next one in the same edge.
    always_comb begin
        nxt_min10 = cur_min10;
        nxt_min01 = cur_min01;
        nxt_sec10 = cur_sec10;
        nxt_sec01 = cur_sec01;
        wrap_all  = 1'b0;
        if (cur_sec01 >= 4'd9) begin
            nxt_sec01 = 4'd0;
            if (cur_sec10 >= 4'd5) begin
                nxt_sec10 = 4'd0;
                if (cur_min01 >= 4'd9) begin
                    nxt_min01 = 4'd0;
                    if (cur_min10 >= 4'd5) begin
                        nxt_min10 = 4'd0;
                        wrap_all  = 1'b1;
                    end else begin
                        nxt_min10 = cur_min10 + 4'd1;
                    end
                end else begin
                    nxt_min01 = cur_min01 + 4'd1;
                end
            end else begin
                nxt_sec10 = cur_sec10 + 4'd1;
            end
        end else begin
            nxt_sec01 = cur_sec01 + 4'd1;
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            presc     <= '0;
            prev_set  <= 1'b0;
            sec_tick  <= 1'b0;
            rollover  <= 1'b0;
            cur_min10 <= 4'd0;
            cur_min01 <= 4'd0;
            cur_sec10 <= 4'd0;
            cur_sec01 <= 4'd0;
        end else begin
            // prev_set keeps tracking set_en even under clear, so a load due this cycle is dropped.
            prev_set <= set_en;
            sec_tick <= 1'b0;
            rollover <= 1'b0;
            if (clear) begin
                presc     <= '0;
                cur_min10 <= 4'd0;
                cur_min01 <= 4'd0;
                cur_sec10 <= 4'd0;
                cur_sec01 <= 4'd0;
            end else if (load_edge) begin
                presc     <= '0;
                cur_min10 <= (set_min10 > 4'd5) ? 4'd0 : set_min10;
                cur_min01 <= (set_min01 > 4'd9) ? 4'd0 : set_min01;
                cur_sec10 <= (set_sec10 > 4'd5) ? 4'd0 : set_sec10;
                cur_sec01 <= (set_sec01 > 4'd9) ? 4'd0 : set_sec01;
            end else if (set_en) begin
                presc <= '0;
            end else if (presc_end) begin
                presc     <= '0;
                sec_tick  <= 1'b1;
                rollover  <= wrap_all;
                cur_min10 <= nxt_min10;
                cur_min01 <= nxt_min01;
                cur_sec10 <= nxt_sec10;
                cur_sec01 <= nxt_sec01;
            end else begin
                presc <= presc + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_clock_counter.sv
// Directed bench for clock_counter with TICK_DIV=4.
module tb_clock_counter;

    logic       MCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       set_en = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] set_min10 = 4'd0, set_min01 = 4'd0, set_sec10 = 4'd0, set_sec01 = 4'd0;
    logic [3:0] cur_min10, cur_min01, cur_sec10, cur_sec01;
    logic       sec_tick, rollover;
    logic [15:0] cur_time;

    int errors = 0;
    int checks = 0;

    assign cur_time = {cur_min10, cur_min01, cur_sec10, cur_sec01};

    always #5 MCLK = ~MCLK;

    clock_counter #(.TICK_DIV(4), .CNT_W(2)) dut (
        .MCLK(MCLK), .RESET(RESET), .set_en(set_en), .clear(clear),
        .set_min10(set_min10), .set_min01(set_min01),
        .set_sec10(set_sec10), .set_sec01(set_sec01),
        .cur_min10(cur_min10), .cur_min01(cur_min01),
        .cur_sec10(cur_sec10), .cur_sec01(cur_sec01),
        .sec_tick(sec_tick), .rollover(rollover)
    );

    task automatic step(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    // One-cycle set_en pulse; the load happens on the edge after set_en falls.
    task automatic load_digits(input logic [3:0] m10, m01, s10, s01);
        set_min10 = m10; set_min01 = m01; set_sec10 = s10; set_sec01 = s01;
        set_en = 1'b1;
        step(1);
        set_en = 1'b0;
        step(1);
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        step(2);
        checks++;
        if ({cur_time, sec_tick, rollover} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state got=%h/%b/%b exp=0000/0/0", cur_time, sec_tick, rollover);
        end
        RESET = 1'b0;
        step(3);
        checks++;
        if (sec_tick !== 1'b0 || cur_time !== 16'h0000) begin
            errors++;
            $display("FAIL reset_early_tick got=%h/%b exp=0000/0", cur_time, sec_tick);
        end
        step(1);
        checks++;
        if (sec_tick !== 1'b1 || cur_time !== 16'h0001) begin
            errors++;
            $display("FAIL reset_first_tick got=%h/%b exp=0001/1", cur_time, sec_tick);
        end
        step(1);
        checks++;
        if (sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick_width got=%b exp=0", sec_tick);
        end
    endtask

    task automatic test_carry;
        load_digits(4'd0, 4'd0, 4'd5, 4'd8);
        checks++;
        if (cur_time !== 16'h0058) begin
            errors++;
            $display("FAIL carry_load got=%h exp=0058", cur_time);
        end
        step(4);
        checks++;
        if (cur_time !== 16'h0059 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL carry_0059 got=%h/%b exp=0059/1", cur_time, sec_tick);
        end
        step(4);
        checks++;
        if (cur_time !== 16'h0100 || sec_tick !== 1'b1 || rollover !== 1'b0) begin
            errors++;
            $display("FAIL carry_0100 got=%h/%b/%b exp=0100/1/0", cur_time, sec_tick, rollover);
        end
    endtask

    task automatic test_rollover;
        load_digits(4'd5, 4'd9, 4'd5, 4'd9);
        step(3);
        checks++;
        if (cur_time !== 16'h5959 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL roll_pre got=%h/%b exp=5959/0", cur_time, sec_tick);
        end
        step(1);
        checks++;
        if (cur_time !== 16'h0000 || sec_tick !== 1'b1 || rollover !== 1'b1) begin
            errors++;
            $display("FAIL roll_wrap got=%h/%b/%b exp=0000/1/1", cur_time, sec_tick, rollover);
        end
        step(1);
        checks++;
        if (sec_tick !== 1'b0 || rollover !== 1'b0) begin
            errors++;
            $display("FAIL roll_width got=%b/%b exp=0/0", sec_tick, rollover);
        end
    endtask

    task automatic test_set_hold;
        int bad = 0;
        load_digits(4'd1, 4'd2, 4'd3, 4'd4);
        set_min10 = 4'd4; set_min01 = 4'd7; set_sec10 = 4'd2; set_sec01 = 4'd1;
        set_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (cur_time !== 16'h1234 || sec_tick !== 1'b0 || rollover !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_frozen got=%0d bad cycles exp=0", bad);
        end
        set_en = 1'b0;
        step(1);
        checks++;
        if (cur_time !== 16'h4721 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL hold_load got=%h/%b exp=4721/0", cur_time, sec_tick);
        end
        step(3);
        checks++;
        if (sec_tick !== 1'b0 || cur_time !== 16'h4721) begin
            errors++;
            $display("FAIL hold_early_tick got=%h/%b exp=4721/0", cur_time, sec_tick);
        end
        step(1);
        checks++;
        if (sec_tick !== 1'b1 || cur_time !== 16'h4722) begin
            errors++;
            $display("FAIL hold_first_tick got=%h/%b exp=4722/1", cur_time, sec_tick);
        end
    endtask

    task automatic test_range;
        load_digits(4'd7, 4'd9, 4'd6, 4'd9);
        checks++;
        if (cur_time !== 16'h0909) begin
            errors++;
            $display("FAIL range_tens got=%h exp=0909", cur_time);
        end
        load_digits(4'd2, 4'd12, 4'd3, 4'd15);
        checks++;
        if (cur_time !== 16'h2030) begin
            errors++;
            $display("FAIL range_units got=%h exp=2030", cur_time);
        end
    endtask

    task automatic test_clear;
        load_digits(4'd3, 4'd3, 4'd3, 4'd3);
        step(2);
        clear = 1'b1;
        step(1);
        checks++;
        if (cur_time !== 16'h0000 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL clear_zero got=%h/%b exp=0000/0", cur_time, sec_tick);
        end
        clear = 1'b0;
        step(3);
        checks++;
        if (sec_tick !== 1'b0 || cur_time !== 16'h0000) begin
            errors++;
            $display("FAIL clear_early_tick got=%h/%b exp=0000/0", cur_time, sec_tick);
        end
        step(1);
        checks++;
        if (sec_tick !== 1'b1 || cur_time !== 16'h0001) begin
            errors++;
            $display("FAIL clear_first_tick got=%h/%b exp=0001/1", cur_time, sec_tick);
        end
    endtask

    task automatic test_clear_discards_load;
        set_min10 = 4'd2; set_min01 = 4'd2; set_sec10 = 4'd2; set_sec01 = 4'd2;
        set_en = 1'b1;
        step(1);
        set_en = 1'b0;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(1);
        checks++;
        if (cur_time !== 16'h0000) begin
            errors++;
            $display("FAIL clear_drop_load got=%h exp=0000", cur_time);
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_carry;
        test_rollover;
        test_set_hold;
        test_range;
        test_clear;
        test_clear_discards_load;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
